// File: rtl/conv_psum_accum.sv
// Partial-sum accumulator behind the systolic array: sums per-pixel results across loop passes,
// then adds bias, saturates and emits final pixels. Optional ReLU on output via PSUM_RELU_EN.
module conv_psum_accum #(
  parameter int DATA_WIDTH        = 16,
  parameter int ACC_WIDTH         = 24,
  parameter int ADDRESS_DATAWIDTH = 13
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [ADDRESS_DATAWIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         first_loop,
  input  logic                         last_loop,
  input  logic [DATA_WIDTH-1:0]        bias,
  input  logic                         in_done,
  output logic                         out_valid,
  output logic [ADDRESS_DATAWIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         done
);

  localparam int DEPTH = 1 << ADDRESS_DATAWIDTH;
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    $signed((ACC_WIDTH+1)'((1 << (DATA_WIDTH-1)) - 1));
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = -SAT_MAX - 1;

  // S0: registered input
  logic                         s0_valid;
  logic [ADDRESS_DATAWIDTH-1:0] s0_addr;
  logic [DATA_WIDTH-1:0]        s0_data;
  logic                         s0_first;
  logic                         s0_last;
  logic [DATA_WIDTH-1:0]        s0_bias;
  logic                         s0_done;

  // S1: RAM read data available
  logic                         s1_valid;
  logic [ADDRESS_DATAWIDTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0]        s1_data;
  logic                         s1_first;
  logic                         s1_last;
  logic [DATA_WIDTH-1:0]        s1_bias;
  logic                         s1_done;
  logic                         s1_fwd;
  logic [ACC_WIDTH-1:0]         s1_fwd_sum;

  // S2: write back or finalise
  logic                         s2_valid;
  logic [ADDRESS_DATAWIDTH-1:0] s2_addr;
  logic [ACC_WIDTH-1:0]         s2_sum;
  logic                         s2_last;
  logic [DATA_WIDTH-1:0]        s2_bias;
  logic                         s2_done;

  logic [ACC_WIDTH-1:0]         mem [DEPTH];
  logic [ACC_WIDTH-1:0]         rd_data;

  logic                         wr_en;
  logic [ACC_WIDTH-1:0]         old_sum;
  logic [ACC_WIDTH-1:0]         new_sum;
  logic signed [ACC_WIDTH:0]    fin;
  logic [DATA_WIDTH-1:0]        sat;
  logic [DATA_WIDTH-1:0]        result;

  assign wr_en = s2_valid && !s2_last;

  // The S2 write lands on the same edge as the S0 read, so a read-first RAM would return stale
  // data; S1 also bypasses the write still sitting in S2.
  always_comb begin
    old_sum = '0;
    if (!s1_first) begin
      if (wr_en && (s2_addr == s1_addr))
        old_sum = s2_sum;
      else if (s1_fwd)
        old_sum = s1_fwd_sum;
      else
        old_sum = rd_data;
    end
    new_sum = old_sum + {{(ACC_WIDTH-DATA_WIDTH){s1_data[DATA_WIDTH-1]}}, s1_data};
  end

  always_comb begin
    fin = $signed({s2_sum[ACC_WIDTH-1], s2_sum})
        + $signed({{(ACC_WIDTH+1-DATA_WIDTH){s2_bias[DATA_WIDTH-1]}}, s2_bias});
    if (fin > SAT_MAX)
      sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (fin < SAT_MIN)
      sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      sat = fin[DATA_WIDTH-1:0];
    result = sat;
`ifdef PSUM_RELU_EN
    if (sat[DATA_WIDTH-1])
      result = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[s2_addr] <= s2_sum;
    if (s0_valid)
      rd_data <= mem[s0_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_valid   <= 1'b0;
      s0_addr    <= '0;
      s0_data    <= '0;
      s0_first   <= 1'b0;
      s0_last    <= 1'b0;
      s0_bias    <= '0;
      s0_done    <= 1'b0;
      s1_valid   <= 1'b0;
      s1_addr    <= '0;
      s1_data    <= '0;
      s1_first   <= 1'b0;
      s1_last    <= 1'b0;
      s1_bias    <= '0;
      s1_done    <= 1'b0;
      s1_fwd     <= 1'b0;
      s1_fwd_sum <= '0;
      s2_valid   <= 1'b0;
      s2_addr    <= '0;
      s2_sum     <= '0;
      s2_last    <= 1'b0;
      s2_bias    <= '0;
      s2_done    <= 1'b0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      done       <= 1'b0;
    end else begin
      s0_valid   <= in_valid;
      s0_addr    <= in_addr;
      s0_data    <= in_data;
      s0_first   <= first_loop;
      s0_last    <= last_loop;
      s0_bias    <= bias;
      s0_done    <= in_done;

      s1_valid   <= s0_valid;
      s1_addr    <= s0_addr;
      s1_data    <= s0_data;
      s1_first   <= s0_first;
      s1_last    <= s0_last;
      s1_bias    <= s0_bias;
      s1_done    <= s0_done;
      s1_fwd     <= s0_valid && wr_en && (s2_addr == s0_addr);
      s1_fwd_sum <= s2_sum;

      s2_valid   <= s1_valid;
      s2_addr    <= s1_addr;
      s2_sum     <= new_sum;
      s2_last    <= s1_last;
      s2_bias    <= s1_bias;
      s2_done    <= s1_done;

      out_valid  <= s2_valid && s2_last;
      done       <= s2_done;
      if (s2_valid && s2_last) begin
        out_addr <= s2_addr;
        out_data <= result;
      end
    end
  end

endmodule

// File: doc/conv_psum_accum.md
Name: conv_psum_accum

Overview:
- Partial-sum accumulator directly downstream of the convolution loop controller and systolic array.
- Each conv layer splits input channels into loop passes; each pass sweeps output addresses 0..N*N-1 once.
- The block sums per-pixel array results across passes in an internal psum RAM.
- On the final pass it adds bias, saturates, optionally applies ReLU, and emits final pixels to the feature-map writer.

Parameters:
DATA_WIDTH, 16, signed width of array results, bias and final output
ACC_WIDTH, 24, signed width of stored partial sums
ADDRESS_DATAWIDTH, 13, output address width; psum RAM depth is 2^ADDRESS_DATAWIDTH

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
in_valid  in  1  array result valid this cycle
in_addr  in  ADDRESS_DATAWIDTH  output pixel address of in_data
in_data  in  DATA_WIDTH  signed array result
first_loop  in  1  current pass is loop 0; overwrite instead of accumulate
last_loop  in  1  current pass is the final loop; produce final output
bias  in  DATA_WIDTH  signed bias of current filter, stable during a pass
in_done  in  1  single-cycle pulse: final address of final loop of final filter accepted
out_valid  out  1  final pixel valid
out_addr  out  ADDRESS_DATAWIDTH  address of final pixel
out_data  out  DATA_WIDTH  final pixel value
done  out  1  single-cycle pulse aligned with the last out_valid of a layer

Behaviour:
- Reset values: out_valid=0, out_addr=0, out_data=0, done=0, and all pipeline valids cleared. RAM contents are not reset. Reset mid-pass discards in-flight data and produces no output.
- Pipeline is 3 stages, no backpressure, and accepts one input per cycle.
- S0, accept cycle:
  - When in_valid=1, issue a RAM read at in_addr.
  - Register addr, data, first_loop, last_loop, bias and in_done.
- S1, read-data cycle:
  - old = 0 if first_loop else RAM read data (sign-extended ACC_WIDTH).
  - sum = old + sign-extend(in_data), computed at ACC_WIDTH with wrap-around.
- S2, write/output cycle:
  - If last_loop=0: write sum to RAM at addr; no output.
  - If last_loop=1:
    - No RAM write.
    - fin = sum + sign-extend(bias), computed at ACC_WIDTH+1.
    - Saturate fin to DATA_WIDTH signed range [-32768, 32767].
    - Drive out_valid=1 with out_addr/out_data on the next clock edge.
  - Latency: in_valid at edge k gives out_valid high after edge k+3.
- Hazard forwarding:
  - If the S1 address equals the S2 write address and S2 is writing, old takes S2's sum instead of RAM data.
  - The same applies for the S0 read against the S2 write issued in the same cycle.
  - RAM is read-first; forwarding makes back-to-back same-address inputs correct.
- first_loop and last_loop both 1 (single-pass layer): output = saturate(in_data + bias); no RAM write.
- in_valid=0 cycles create bubbles and have no effect on RAM or outputs.
- done: in_done travels with its data through the pipeline.
  - done=1 for exactly one cycle, in the same cycle as that pixel's out_valid.
  - If in_done arrives with in_valid=0, done still pulses 3 cycles later with out_valid=0.
- Flags are sampled per input, so a pass boundary between consecutive cycles is handled with no idle cycle.

Optional Feature:
- Macro PSUM_RELU_EN.
- When defined: after saturation, negative results output 0 (ReLU); out_data is never negative.
- When undefined: the saturated signed value is output unchanged.
- Latency is identical in both builds.

Test Plan:
- Single pass, first_loop=last_loop=1, bias=5, in_data=100 at addr 7 -> 3 cycles later out_valid=1, out_addr=7, out_data=105.
- Two passes over addrs 0..3:
  - Pass 0 data 10,20,30,40; pass 1 data 1,2,3,4 with last_loop=1, bias=-1.
  - Expect outputs 10,21,32,43 in order, no outputs during pass 0.
- Saturation with bias=0:
  - Three passes of 20000 at addr 0 -> out_data=32767.
  - Three passes of -20000 -> -32768, or 0 with PSUM_RELU_EN.
- Back-to-back same address:
  - addr 5 data 3 (first_loop=1, last_loop=0), next cycle addr 5 data 4 (last_loop=1), bias=0.
  - Expect out_data=7 (forwarding path).
- Bubbles plus done:
  - Alternate in_valid over a 4-address final pass, in_done on the last input.
  - done pulses once, aligned with the addr 3 output; out_valid count is 4.
- Reset asserted during pass 1 with 2 inputs in flight -> no out_valid or done after release; outputs read 0.
